// File: rtl/tl_a_pkg.sv
// Shared TileLink A-channel types: opcode constants, the stored beat layout
// and the burst-length helper used when tagging first/last beats.
package tl_a_pkg;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] ARITH       = 3'd2;
    localparam logic [2:0] LOGIC       = 3'd3;
    localparam logic [2:0] GET         = 3'd4;
    localparam logic [2:0] HINT        = 3'd5;
    localparam logic [2:0] ACQUIRE     = 3'd6;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [8:0]  source;
        logic [31:0] address;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        corrupt;
        logic        first;
        logic        last;
    } tl_a_beat_t;

    // Only Puts carry data; one 64-bit beat covers 8 bytes, so size 7 -> 16 beats.
    function automatic logic [4:0] num_beats(input logic [2:0] opcode, input logic [2:0] size);
        logic has_data;
        has_data = (opcode == PUT_FULL) || (opcode == PUT_PARTIAL);
        if (has_data && (size > 3'd3))
            num_beats = 5'd1 << (size - 3'd3);
        else
            num_beats = 5'd1;
    endfunction

endpackage

// File: rtl/tl_beat_tracker.sv
// Input-side beat counter: tags each enqueued beat with first/last of its message.
// Latency: first/last are combinational from the current opcode/size; counter updates on fire.
// Backpressure: none of its own; advances only on an accepted beat.
module tl_beat_tracker
    import tl_a_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       fire,
    input  logic [2:0] opcode,
    input  logic [2:0] size,
    output logic       first,
    output logic       last
);

    logic [3:0] icnt;
    logic [4:0] beats;

    assign beats = num_beats(opcode, size);
    assign first = (icnt == 4'd0);
    assign last  = ({1'b0, icnt} == (beats - 5'd1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            icnt <= 4'd0;
        else if (fire)
            icnt <= last ? 4'd0 : icnt + 4'd1;
    end

endmodule

// File: rtl/tl_a_channel_queue.sv
// TileLink A-channel buffer ahead of the crossing; optional bypass via TL_A_QUEUE_FLOW_EN.
// Latency: 1 cycle enqueue->out_valid (0 cycles when bypassing an empty queue).
// Backpressure: in_ready drops when the registered count reaches DEPTH.
module tl_a_channel_queue
    import tl_a_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [2:0]        in_param,
    input  logic [2:0]        in_size,
    input  logic [8:0]        in_source,
    input  logic [31:0]       in_address,
    input  logic [7:0]        in_mask,
    input  logic [63:0]       in_data,
    input  logic              in_corrupt,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_opcode,
    output logic [2:0]        out_param,
    output logic [2:0]        out_size,
    output logic [8:0]        out_source,
    output logic [31:0]       out_address,
    output logic [7:0]        out_mask,
    output logic [63:0]       out_data,
    output logic              out_corrupt,
    output logic              out_first,
    output logic              out_last,

    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tl_a_beat_t        mem [DEPTH];
    tl_a_beat_t        in_beat;
    tl_a_beat_t        head;
    tl_a_beat_t        out_beat;
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic              enq;
    logic              deq;
    logic              push;
    logic              in_first;
    logic              in_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready = (count != CNT_W'(DEPTH));
    assign enq      = in_valid && in_ready;

    tl_beat_tracker u_tracker (
        .clock   (clock),
        .reset_n (reset_n),
        .fire    (enq),
        .opcode  (in_opcode),
        .size    (in_size),
        .first   (in_first),
        .last    (in_last)
    );

    assign in_beat = '{
        opcode:  in_opcode,
        param:   in_param,
        size:    in_size,
        source:  in_source,
        address: in_address,
        mask:    in_mask,
        data:    in_data,
        corrupt: in_corrupt,
        first:   in_first,
        last:    in_last
    };

    assign head = mem[rp];

`ifdef TL_A_QUEUE_FLOW_EN
    logic bypass;

    // An empty queue forwards the live input; a taken bypass beat is never stored.
    assign bypass    = (count == '0) && in_valid;
    assign out_valid = (count != '0) || in_valid;
    assign out_beat  = bypass ? in_beat : head;
    assign push      = enq && !(bypass && out_ready);
    assign deq       = (count != '0) && out_ready;
`else
    assign out_valid = (count != '0);
    assign out_beat  = head;
    assign push      = enq;
    assign deq       = out_valid && out_ready;
`endif

    assign out_opcode  = out_beat.opcode;
    assign out_param   = out_beat.param;
    assign out_size    = out_beat.size;
    assign out_source  = out_beat.source;
    assign out_address = out_beat.address;
    assign out_mask    = out_beat.mask;
    assign out_data    = out_beat.data;
    assign out_corrupt = out_beat.corrupt;
    assign out_first   = out_beat.first;
    assign out_last    = out_beat.last;

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clock) begin
        if (push)
            mem[wp] <= in_beat;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push)
                wp <= ptr_inc(wp);
            if (deq)
                rp <= ptr_inc(rp);
            case ({push, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_a_channel_queue.sv
// Randomized + directed bench for tl_a_channel_queue against a queue-based reference model.
module tb_tl_a_channel_queue;
    import tl_a_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_opcode = '0;
    logic [2:0]        in_param = '0;
    logic [2:0]        in_size = '0;
    logic [8:0]        in_source = '0;
    logic [31:0]       in_address = '0;
    logic [7:0]        in_mask = '0;
    logic [63:0]       in_data = '0;
    logic              in_corrupt = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2:0]        out_opcode;
    logic [2:0]        out_param;
    logic [2:0]        out_size;
    logic [8:0]        out_source;
    logic [31:0]       out_address;
    logic [7:0]        out_mask;
    logic [63:0]       out_data;
    logic              out_corrupt;
    logic              out_first;
    logic              out_last;
    logic [CNT_W-1:0]  count;

    tl_a_channel_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_param(in_param), .in_size(in_size),
        .in_source(in_source), .in_address(in_address), .in_mask(in_mask),
        .in_data(in_data), .in_corrupt(in_corrupt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_param(out_param), .out_size(out_size),
        .out_source(out_source), .out_address(out_address), .out_mask(out_mask),
        .out_data(out_data), .out_corrupt(out_corrupt),
        .out_first(out_first), .out_last(out_last),
        .count(count)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    tl_a_beat_t model_q[$];
    int         rem = 0;      // beats still owed by the message in progress
    logic       accepted;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [28:0] misc_of(input tl_a_beat_t b);
        misc_of = {b.opcode, b.param, b.size, b.source, b.mask, b.corrupt, b.first, b.last};
    endfunction

    function automatic int msg_beats(input logic [2:0] op, input logic [2:0] sz);
        if ((op == 3'd0 || op == 3'd1) && sz > 3'd3)
            return 2 ** (int'(sz) - 3);
        return 1;
    endfunction

    // Beat currently on the inputs, tagged from the model's message bookkeeping.
    function automatic tl_a_beat_t cur_in();
        tl_a_beat_t b;
        int r;
        r = (rem == 0) ? msg_beats(in_opcode, in_size) : rem;
        b = '{opcode: in_opcode, param: in_param, size: in_size, source: in_source,
              address: in_address, mask: in_mask, data: in_data, corrupt: in_corrupt,
              first: (rem == 0), last: (r == 1)};
        return b;
    endfunction

    task automatic cycle();
        logic exp_vld, exp_rdy, enq_m, deq_m, byp;
        tl_a_beat_t hb, ib;
        @(negedge clock);
        ib = cur_in();
        exp_rdy = (model_q.size() != DEPTH);
        byp = 1'b0;
`ifdef TL_A_QUEUE_FLOW_EN
        byp = (model_q.size() == 0) && in_valid;
`endif
        exp_vld = (model_q.size() != 0) || byp;
        hb = byp ? ib : ((model_q.size() != 0) ? model_q[0] : ib);
        chk("count", 64'(count), 64'(model_q.size()));
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(exp_vld));
        if (exp_vld) begin
            chk("out_data", out_data, hb.data);
            chk("out_address", 64'(out_address), 64'(hb.address));
            chk("out_misc", 64'({out_opcode, out_param, out_size, out_source, out_mask,
                                 out_corrupt, out_first, out_last}), 64'(misc_of(hb)));
        end
        enq_m = in_valid && exp_rdy;
        deq_m = exp_vld && out_ready;
        @(posedge clock);
        if (deq_m && !byp)
            void'(model_q.pop_front());
        if (enq_m && !(byp && out_ready))
            model_q.push_back(ib);
        if (enq_m)
            rem = (rem == 0 ? msg_beats(ib.opcode, ib.size) : rem) - 1;
        accepted = enq_m;
        #1;
    endtask

    task automatic set_beat(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [8:0] src, input logic [63:0] dat);
        in_opcode  = op;
        in_size    = sz;
        in_address = addr;
        in_source  = src;
        in_data    = dat;
        in_param   = 3'($urandom_range(0, 7));
        in_mask    = 8'($urandom);
        in_corrupt = 1'($urandom);
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [8:0] src, input logic [63:0] dat);
        set_beat(op, sz, addr, src, dat);
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 200 && !accepted; i++)
            cycle();
        if (!accepted)
            chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        reset_n = 1'b1;
        idle(2);

        // Single-beat Get
        out_ready = 1'b1;
        send(GET, 3'd6, 32'h8000_0040, 9'h1A, 64'h0123_4567_89AB_CDEF);
        idle(3);

        // 4-beat PutFull against a stalled sink, then drain
        out_ready = 1'b0;
        send(PUT_FULL, 3'd5, 32'h1000_0000, 9'h05, 64'h11);
        send(PUT_FULL, 3'd5, 32'h1000_0000, 9'h05, 64'h22);
        set_beat(PUT_FULL, 3'd5, 32'h1000_0000, 9'h05, 64'h33);
        in_valid = 1'b1;
        idle(3);
        out_ready = 1'b1;
        send(PUT_FULL, 3'd5, 32'h1000_0000, 9'h05, 64'h33);
        send(PUT_FULL, 3'd5, 32'h1000_0000, 9'h05, 64'h44);
        idle(4);

        // Full queue with enqueue and dequeue both requested
        out_ready = 1'b0;
        send(GET, 3'd2, 32'h2000_0000, 9'h01, 64'hA1);
        send(GET, 3'd2, 32'h2000_0008, 9'h02, 64'hA2);
        set_beat(GET, 3'd2, 32'h2000_0010, 9'h03, 64'hA3);
        in_valid = 1'b1;
        out_ready = 1'b1;
        idle(1);
        set_beat(GET, 3'd2, 32'h2000_0018, 9'h04, 64'hA4);
        idle(1);
        in_valid = 1'b0;
        idle(4);

        // Reset in the middle of an 8-beat PutPartial
        out_ready = 1'b0;
        send(PUT_PARTIAL, 3'd6, 32'h3000_0000, 9'h07, 64'hB1);
        send(PUT_PARTIAL, 3'd6, 32'h3000_0000, 9'h07, 64'hB2);
        reset_n = 1'b0;
        #2;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        model_q.delete();
        rem = 0;
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(GET, 3'd3, 32'h4000_0000, 9'h09, 64'hC1);
        idle(3);

        // Empty queue, sink ready: bypasses when the flow option is built in
        send(GET, 3'd3, 32'h5000_0000, 9'h0B, 64'hDEAD_BEEF);
        idle(2);

        // Randomized messages with random valid/ready timing
        for (int m = 0; m < 250; m++) begin
            logic [2:0] op, sz;
            logic [31:0] addr;
            logic [8:0]  src;
            int nb;
            op   = 3'($urandom_range(0, 6));
            sz   = 3'($urandom_range(0, 7));
            addr = $urandom;
            src  = 9'($urandom);
            nb   = msg_beats(op, sz);
            for (int b = 0; b < nb; b++) begin
                set_beat(op, sz, addr, src, {$urandom, $urandom});
                accepted = 1'b0;
                for (int t = 0; t < 200 && !accepted; t++) begin
                    in_valid  = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 2) != 0);
                    cycle();
                end
                if (!accepted)
                    chk("rand_accept_timeout", 64'd0, 64'd1);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(DEPTH + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
